icache: RTL and testbench
=========================

Name: icache

Overview:
- Direct-mapped instruction cache. It is the responder on the fetch interface: it receives the fetch stage's `proc2Imem_addr` and returns `Imem2proc_data`.
- It adds `Imem2proc_valid` so fetch can stall on a miss.
- Misses are filled from main memory over a tagged request/response interface. At most one fill is outstanding at a time.
- It sits between the fetch stage and the memory arbiter.

Parameters:
- NUM_LINES, 32, number of cache lines; must be a power of 2, at least 2.
- IDX_W, $clog2(NUM_LINES), index width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- proc2Imem_addr  in  32  fetch address; bits [1:0] ignored
- Imem2proc_data  out  32  instruction word at proc2Imem_addr; 0 when not valid
- Imem2proc_valid  out  1  high when Imem2proc_data is a hit this cycle
- proc2Mem_req  out  1  line-fill request
- proc2Mem_addr  out  32  line-aligned fill address, bits [2:0]=0
- Mem2proc_response  in  4  nonzero = request accepted with that tag; 0 = rejected, retry
- Mem2proc_data  in  64  fill data; [31:0] = word at +0, [63:32] = word at +4
- Mem2proc_tag  in  4  nonzero = Mem2proc_data belongs to that tag; 0 = no return

Behaviour:
- Reset is rst, synchronous, active-high, on clock clk.
- Address split:
  - line = 64 bits (2 words);
  - word select = addr[2];
  - index = addr[IDX_W+2:3];
  - tag = addr[31:IDX_W+3].
- Storage per line: valid bit, tag, 64-bit data.
- Hit = line[index].valid && line[index].tag == addr tag. Hit is combinational, zero latency:
  - Imem2proc_valid = hit;
  - Imem2proc_data = selected word on a hit, else 0.
- FSM states are IDLE and WAIT. Registers: mem_tag (4 bits), fill_addr (32 bits).
- IDLE behaviour:
  - On a miss, drive proc2Mem_req=1 and proc2Mem_addr={addr[31:3],3'b0} combinationally. Outside IDLE-miss, both are 0.
  - If Mem2proc_response!=0 in the same cycle: latch mem_tag=response and fill_addr=proc2Mem_addr, then go to WAIT.
  - If Mem2proc_response==0: stay in IDLE and re-request next cycle for the then-current address.
- WAIT behaviour:
  - proc2Mem_req=0.
  - When Mem2proc_tag!=0 && Mem2proc_tag==mem_tag: write Mem2proc_data into line fill_addr index, set valid and tag, clear mem_tag to 0, and go to IDLE.
  - Non-matching tags are ignored.
- Fill timing: the fill is written at the clock edge. Lookups in the fill cycle see the old contents, so the hit appears the cycle after the return. There is no bypass.
- Hit-under-miss: in WAIT, a hit on any address is served normally. A second miss issues no request until back in IDLE.
- Address changes during WAIT: the outstanding fill still completes into fill_addr's line. The new address is then handled in IDLE.
- Fill index conflict: a fill to the index currently being looked up overwrites that line (direct-mapped eviction, no writeback).
- Tag 0: never matches, so mem_tag==0 means nothing is outstanding.
- Reset values:
  - all valid bits 0, state IDLE, mem_tag 0, fill_addr 0;
  - while rst=1, proc2Mem_req=0, Imem2proc_valid=0, Imem2proc_data=0.
- Reset mid-WAIT: the fill is abandoned. A later return with the old tag is ignored (mem_tag=0). Tag and data arrays need no reset.

Test Plan:
- Reset, addr=0x0 -> Imem2proc_valid=0 and Imem2proc_data=0 during rst. After rst, proc2Mem_req=1, proc2Mem_addr=0x0.
- Cold miss, addr=0x0:
  - Stimulus: response=3, then 5 idle cycles, then tag=3 with data=0x00000013_00100093.
  - Required: req drops after acceptance; valid=0 in the return cycle.
  - Next cycle: valid=1, data=0x00100093.
  - addr=0x4: hit, data=0x00000013.
- Retry: miss at 0x20 with response=0,0,5 -> proc2Mem_req high 3 consecutive cycles with addr 0x20; WAIT entered after the 3rd.
- Conflict (NUM_LINES=32): fill 0x0, then fill 0x100 (same index 0) -> 0x100 hits; 0x0 misses again and re-requests 0x0.
- Hit-under-miss: 0x0 cached, miss at 0x40 outstanding (tag 2), addr switched to 0x0 -> valid=1 during WAIT. A return with tag 7 is ignored; tag 2 fills line 8.
- Reset in WAIT: miss at 0x0 accepted with tag 4, rst pulsed, then tag=4 returned -> no fill; 0x0 still misses and issues a new request.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped instruction cache between the fetch stage and the memory
// arbiter. Lookups are combinational. A miss issues one line-fill request
// at a time over the tagged memory interface and stalls fetch through
// Imem2proc_valid until the line has been written.
module icache #(
    parameter int NUM_LINES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] proc2Imem_addr,
    output logic [31:0] Imem2proc_data,
    output logic        Imem2proc_valid,
    output logic        proc2Mem_req,
    output logic [31:0] proc2Mem_addr,
    input  logic [3:0]  Mem2proc_response,
    input  logic [63:0] Mem2proc_data,
    input  logic [3:0]  Mem2proc_tag
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 29 - IDX_W;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state;
    logic [3:0] mem_tag;
    // Line address of the outstanding fill; bits [2:0] are always zero.
    logic [31:3] fill_addr;

    logic [NUM_LINES-1:0] line_valid;
    logic [TAG_W-1:0] line_tag [NUM_LINES];
    logic [63:0] line_data [NUM_LINES];

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic hit;
    logic fill_en;

    assign req_idx  = proc2Imem_addr[IDX_W+2:3];
    assign req_tag  = proc2Imem_addr[31:IDX_W+3];
    assign fill_idx = fill_addr[IDX_W+2:3];
    assign fill_tag = fill_addr[31:IDX_W+3];

    // A return completes the fill only when it carries the outstanding tag;
    // mem_tag is 0 when nothing is outstanding, and tag 0 never matches.
    assign fill_en = !rst && (state == WAIT) && (Mem2proc_tag != 4'd0)
                     && (Mem2proc_tag == mem_tag);

    // Zero-latency lookup, fill request on an IDLE miss; all quiet during reset.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        hit             = 1'b0;
        Imem2proc_valid = 1'b0;
        Imem2proc_data  = 32'd0;
        proc2Mem_req    = 1'b0;
        proc2Mem_addr   = 32'd0;
        if (!rst) begin
            hit = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
            Imem2proc_valid = hit;
            if (hit) begin
                Imem2proc_data = proc2Imem_addr[2] ? line_data[req_idx][63:32]
                                                   : line_data[req_idx][31:0];
            end
            if (state == IDLE && !hit) begin
                proc2Mem_req  = 1'b1;
                proc2Mem_addr = {proc2Imem_addr[31:3], 3'b000};
            end
        end
    end

    // Request/return FSM plus the per-line valid bits.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state      <= IDLE;
            mem_tag    <= 4'd0;
            fill_addr  <= '0;
            line_valid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (proc2Mem_req && Mem2proc_response != 4'd0) begin
                        mem_tag   <= Mem2proc_response;
                        fill_addr <= proc2Mem_addr[31:3];
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (fill_en) begin
                        line_valid[fill_idx] <= 1'b1;
                        mem_tag              <= 4'd0;
                        state                <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays written on a completed fill.
    always_ff @(posedge clk) begin
        // NOTE: arrays are not reset; line_valid alone decides whether their contents mean anything.
        if (fill_en) begin
            line_tag[fill_idx]  <= fill_tag;
            line_data[fill_idx] <= Mem2proc_data;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache (NUM_LINES = 32).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// sampled 1 time unit after that, well clear of the next edge.
module tb_icache;

    logic        clk;
    logic        rst;
    logic [31:0] proc2Imem_addr;
    logic [31:0] Imem2proc_data;
    logic        Imem2proc_valid;
    logic        proc2Mem_req;
    logic [31:0] proc2Mem_addr;
    logic [3:0]  Mem2proc_response;
    logic [63:0] Mem2proc_data;
    logic [3:0]  Mem2proc_tag;

    int pass_cnt = 0;
    int total_cnt = 0;

    icache #(.NUM_LINES(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .proc2Imem_addr   (proc2Imem_addr),
        .Imem2proc_data   (Imem2proc_data),
        .Imem2proc_valid  (Imem2proc_valid),
        .proc2Mem_req     (proc2Mem_req),
        .proc2Mem_addr    (proc2Mem_addr),
        .Mem2proc_response(Mem2proc_response),
        .Mem2proc_data    (Mem2proc_data),
        .Mem2proc_tag     (Mem2proc_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        proc2Imem_addr = 32'h0;
        Mem2proc_response = 4'd0;
        Mem2proc_data = 64'd0;
        Mem2proc_tag = 4'd0;
        settle();
        total_cnt++;
        if (Imem2proc_valid !== 1'b0 || Imem2proc_data !== 32'd0 || proc2Mem_req !== 1'b0)
            $display("FAIL reset_outputs_pre_edge: valid=%b data=%h req=%b, need 0/0/0",
                     Imem2proc_valid, Imem2proc_data, proc2Mem_req);
        else pass_cnt++;
        tick(); tick();
        settle();
        total_cnt++;
        if (Imem2proc_valid !== 1'b0 || Imem2proc_data !== 32'd0 || proc2Mem_req !== 1'b0)
            $display("FAIL reset_outputs: valid=%b data=%h req=%b, need 0/0/0",
                     Imem2proc_valid, Imem2proc_data, proc2Mem_req);
        else pass_cnt++;
        rst = 1'b0;
        settle();
        total_cnt++;
        if (proc2Mem_req !== 1'b1 || proc2Mem_addr !== 32'h0)
            $display("FAIL reset_first_req: req=%b addr=%h, need 1/00000000",
                     proc2Mem_req, proc2Mem_addr);
        else pass_cnt++;
    endtask

    task automatic test_cold_miss();
        Mem2proc_response = 4'd3;
        settle();
        tick();
        Mem2proc_response = 4'd0;
        settle();
        total_cnt++;
        if (proc2Mem_req !== 1'b0)
            $display("FAIL cold_req_drops: req=%b, need 0", proc2Mem_req);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) tick();
        settle();
        total_cnt++;
        if (Imem2proc_valid !== 1'b0 || proc2Mem_req !== 1'b0)
            $display("FAIL cold_wait_idle: valid=%b req=%b, need 0/0",
                     Imem2proc_valid, proc2Mem_req);
        else pass_cnt++;
        Mem2proc_tag = 4'd3;
        Mem2proc_data = 64'h00000013_00100093;
        settle();
        total_cnt++;
        if (Imem2proc_valid !== 1'b0)
            $display("FAIL cold_return_cycle: valid=%b, need 0", Imem2proc_valid);
        else pass_cnt++;
        tick();
        Mem2proc_tag = 4'd0;
        Mem2proc_data = 64'd0;
        settle();
        total_cnt++;
        if (Imem2proc_valid !== 1'b1 || Imem2proc_data !== 32'h00100093)
            $display("FAIL cold_hit_word0: valid=%b data=%h, need 1/00100093",
                     Imem2proc_valid, Imem2proc_data);
        else pass_cnt++;
        proc2Imem_addr = 32'h4;
        settle();
        total_cnt++;
        if (Imem2proc_valid !== 1'b1 || Imem2proc_data !== 32'h00000013)
            $display("FAIL cold_hit_word1: valid=%b data=%h, need 1/00000013",
                     Imem2proc_valid, Imem2proc_data);
        else pass_cnt++;
    endtask

    task automatic test_retry();
        logic [3:0] resp_seq [3];
        resp_seq[0] = 4'd0;
        resp_seq[1] = 4'd0;
        resp_seq[2] = 4'd5;
        proc2Imem_addr = 32'h20;
        for (int i = 0; i < 3; i++) begin
            Mem2proc_response = resp_seq[i];
            settle();
            total_cnt++;
            if (proc2Mem_req !== 1'b1 || proc2Mem_addr !== 32'h20)
                $display("FAIL retry_req_%0d: req=%b addr=%h, need 1/00000020",
                         i, proc2Mem_req, proc2Mem_addr);
            else pass_cnt++;
            tick();
        end
        Mem2proc_response = 4'd0;
        settle();
        total_cnt++;
        if (proc2Mem_req !== 1'b0)
            $display("FAIL retry_in_wait: req=%b, need 0", proc2Mem_req);
        else pass_cnt++;
        Mem2proc_tag = 4'd5;
        Mem2proc_data = 64'hDEADBEEF_CAFEF00D;
        tick();
        Mem2proc_tag = 4'd0;
        proc2Imem_addr = 32'h24;
        settle();
        total_cnt++;
        if (Imem2proc_valid !== 1'b1 || Imem2proc_data !== 32'hDEADBEEF)
            $display("FAIL retry_fill_hit: valid=%b data=%h, need 1/deadbeef",
                     Imem2proc_valid, Imem2proc_data);
        else pass_cnt++;
    endtask

    task automatic test_conflict();
        proc2Imem_addr = 32'h100;
        Mem2proc_response = 4'd6;
        settle();
        tick();
        Mem2proc_response = 4'd0;
        Mem2proc_tag = 4'd6;
        Mem2proc_data = 64'hAAAABBBB_CCCCDDDD;
        tick();
        Mem2proc_tag = 4'd0;
        settle();
        total_cnt++;
        if (Imem2proc_valid !== 1'b1 || Imem2proc_data !== 32'hCCCCDDDD)
            $display("FAIL conflict_new_hit: valid=%b data=%h, need 1/ccccdddd",
                     Imem2proc_valid, Imem2proc_data);
        else pass_cnt++;
        proc2Imem_addr = 32'h0;
        settle();
        total_cnt++;
        if (Imem2proc_valid !== 1'b0 || proc2Mem_req !== 1'b1 || proc2Mem_addr !== 32'h0)
            $display("FAIL conflict_evicted: valid=%b req=%b addr=%h, need 0/1/00000000",
                     Imem2proc_valid, proc2Mem_req, proc2Mem_addr);
        else pass_cnt++;
        // Refill 0x0 so the next scenario starts with it cached.
        Mem2proc_response = 4'd1;
        tick();
        Mem2proc_response = 4'd0;
        Mem2proc_tag = 4'd1;
        Mem2proc_data = 64'h00000013_00100093;
        tick();
        Mem2proc_tag = 4'd0;
        settle();
        total_cnt++;
        if (Imem2proc_valid !== 1'b1 || Imem2proc_data !== 32'h00100093)
            $display("FAIL conflict_refill: valid=%b data=%h, need 1/00100093",
                     Imem2proc_valid, Imem2proc_data);
        else pass_cnt++;
    endtask

    task automatic test_hit_under_miss();
        proc2Imem_addr = 32'h40;
        Mem2proc_response = 4'd2;
        settle();
        tick();
        Mem2proc_response = 4'd0;
        proc2Imem_addr = 32'h0;
        settle();
        total_cnt++;
        if (Imem2proc_valid !== 1'b1 || Imem2proc_data !== 32'h00100093 || proc2Mem_req !== 1'b0)
            $display("FAIL hum_hit_in_wait: valid=%b data=%h req=%b, need 1/00100093/0",
                     Imem2proc_valid, Imem2proc_data, proc2Mem_req);
        else pass_cnt++;
        Mem2proc_tag = 4'd7;
        Mem2proc_data = 64'hBADBAD00_BADBAD00;
        tick();
        Mem2proc_tag = 4'd0;
        proc2Imem_addr = 32'h40;
        settle();
        total_cnt++;
        if (Imem2proc_valid !== 1'b0 || proc2Mem_req !== 1'b0)
            $display("FAIL hum_wrong_tag_ignored: valid=%b req=%b, need 0/0",
                     Imem2proc_valid, proc2Mem_req);
        else pass_cnt++;
        Mem2proc_tag = 4'd2;
        Mem2proc_data = 64'h11112222_33334444;
        tick();
        Mem2proc_tag = 4'd0;
        settle();
        total_cnt++;
        if (Imem2proc_valid !== 1'b1 || Imem2proc_data !== 32'h33334444)
            $display("FAIL hum_fill_word0: valid=%b data=%h, need 1/33334444",
                     Imem2proc_valid, Imem2proc_data);
        else pass_cnt++;
        proc2Imem_addr = 32'h44;
        settle();
        total_cnt++;
        if (Imem2proc_valid !== 1'b1 || Imem2proc_data !== 32'h11112222)
            $display("FAIL hum_fill_word1: valid=%b data=%h, need 1/11112222",
                     Imem2proc_valid, Imem2proc_data);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_wait();
        // Pulse reset to invalidate everything, then take a miss at 0x0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        proc2Imem_addr = 32'h0;
        Mem2proc_response = 4'd4;
        settle();
        tick();
        Mem2proc_response = 4'd0;
        settle();
        total_cnt++;
        if (proc2Mem_req !== 1'b0 || Imem2proc_valid !== 1'b0)
            $display("FAIL rstwait_in_wait: req=%b valid=%b, need 0/0",
                     proc2Mem_req, Imem2proc_valid);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        Mem2proc_tag = 4'd4;
        Mem2proc_data = 64'h55555555_66666666;
        tick();
        Mem2proc_tag = 4'd0;
        settle();
        total_cnt++;
        if (Imem2proc_valid !== 1'b0 || Imem2proc_data !== 32'd0)
            $display("FAIL rstwait_no_fill: valid=%b data=%h, need 0/00000000",
                     Imem2proc_valid, Imem2proc_data);
        else pass_cnt++;
        total_cnt++;
        if (proc2Mem_req !== 1'b1 || proc2Mem_addr !== 32'h0)
            $display("FAIL rstwait_new_req: req=%b addr=%h, need 1/00000000",
                     proc2Mem_req, proc2Mem_addr);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        proc2Imem_addr = 32'h0;
        Mem2proc_response = 4'd0;
        Mem2proc_data = 64'd0;
        Mem2proc_tag = 4'd0;
        test_reset();
        test_cold_miss();
        test_retry();
        test_conflict();
        test_hit_under_miss();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
